alu_cmd_issuer: RTL
===================

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 Parameter IN_WIDTH, default 5: width of operands A and B (signed).
REQ-002 Parameter OUT_WIDTH, default 6: width of ALU result C.
REQ-003 Parameter DEPTH, default 4: command FIFO depth; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 cmd_valid  input  1  upstream command valid.
REQ-007 cmd_ready  output  1  FIFO can accept a command.
REQ-008 cmd_a, cmd_b  input  IN_WIDTH each  signed command operands.
REQ-009 cmd_a_en, cmd_b_en  input  1 each  command operand-group enables.
REQ-010 cmd_a_op  input  3 / cmd_b_op  input  2  command opcodes.
REQ-011 A, B  output  IN_WIDTH each  operands to ALU.
REQ-012 a_en, b_en  output  1 each / a_op  output  3 / b_op  output  2  control to ALU.
REQ-013 ALU_en  output  1  ALU strobe.
REQ-014 C  input  OUT_WIDTH  ALU result; valid in the cycle after the cycle in which ALU_en=1.
REQ-015 res_valid  output  1 / res_ready  input  1 / res_data  output  OUT_WIDTH  result handshake to downstream.
REQ-016 issued_cnt  output  8  count of completed results; wraps 255 -> 0.

Function
REQ-017 Push: a command is written into the FIFO on a rising edge where cmd_valid && cmd_ready.
REQ-018 cmd_ready = FIFO not full; cmd_ready is combinational from the FIFO count only.
REQ-019 Push while full is impossible because cmd_ready=0; cmd_valid during full is held by upstream and not lost.
REQ-020 FIFO order is strict FIFO; read and write pointers wrap modulo DEPTH; an occupancy counter 0..DEPTH is maintained.
REQ-021 FSM states: IDLE, ISSUE, WAIT, HOLD.
REQ-022 IDLE -> ISSUE when the FIFO is non-empty; the FIFO head is popped on that edge and loaded into the A/B/a_en/b_en/a_op/b_op registers.
REQ-023 In ISSUE: ALU_en=1 for exactly one cycle; next state is WAIT unconditionally.
REQ-024 In WAIT: ALU_en=0; on the edge ending WAIT, res_data <= C, res_valid <= 1, and state -> HOLD.
REQ-025 In HOLD: res_valid=1 and res_data is stable until res_valid && res_ready.
REQ-026 HOLD on handshake: issued_cnt increments, res_valid clears, and the next state is ISSUE (with pop) if the FIFO is non-empty, else IDLE.
REQ-027 Simultaneous push and pop in the same cycle are both performed; occupancy is unchanged.
REQ-028 A push into an empty FIFO is not bypassed; the command reaches ISSUE no earlier than 2 edges after the push edge.
REQ-029 Latency with FIFO empty and FSM in IDLE: res_valid rises 4 edges after the push edge (push, ->ISSUE, ->WAIT, ->HOLD).
REQ-030 Throughput: at most one command per 3 cycles (ISSUE, WAIT, HOLD) with res_ready held at 1.
REQ-031 A, B, a_en, b_en, a_op and b_op are registered and hold their value outside ISSUE.
REQ-032 ALU_en=1 only in ISSUE.
REQ-033 C is sampled only on the edge ending WAIT.

Reset
REQ-034 On rst_n=0, asynchronously: FIFO empty, pointers 0, state IDLE, A=B=0, a_en=b_en=0, a_op=0, b_op=0, ALU_en=0, res_valid=0, res_data=0, issued_cnt=0.
REQ-035 While rst_n=0, cmd_ready=1 (FIFO empty) but no push is recorded.
REQ-036 Reset mid-operation (ISSUE, WAIT or HOLD) discards the in-flight command, any pending result, and all queued commands.
REQ-037 The first edge after rst_n deasserts is a normal operating edge.

Verification
REQ-038 Single command: push A=5, B=-3, a_en=1, a_op=0, res_ready=1. ALU_en pulses for one cycle carrying A=5 and B=-3. res_data equals C from the WAIT cycle, res_valid rises 4 edges after the push, and issued_cnt=1.
REQ-039 Fill: push 5 commands back-to-back with the FSM stalled in HOLD and res_ready=0. cmd_ready drops after 4 queued commands. The 5th command is held and accepted when a pop frees a slot.
REQ-040 Ordering: push 4 commands with distinct A values 1,2,3,4 and res_ready=1. ALU_en pulses appear 3 cycles apart with A=1,2,3,4 in order.
REQ-041 Backpressure: res_ready=0 for 10 cycles in HOLD. res_valid and res_data stay stable, no further ALU_en pulse occurs, and the FIFO continues accepting commands until full.
REQ-042 Reset in WAIT: assert rst_n=0 mid-cycle. All outputs clear immediately and stay clear. After release, with no new pushes, no ALU_en pulse and no res_valid occur.
REQ-043 Counter wrap: complete 256 results. issued_cnt returns to 0.

Source files
------------

// File: rtl/alu_cmd_issuer_if.sv
// Bundle of command, ALU-control and result handshake signals shared between
// the command issuer (slave side) and its upstream/ALU/downstream neighbours.
interface alu_cmd_issuer_if #(
  parameter int IN_WIDTH  = 5,
  parameter int OUT_WIDTH = 6
);
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic signed [IN_WIDTH-1:0]  cmd_a;
  logic signed [IN_WIDTH-1:0]  cmd_b;
  logic                        cmd_a_en;
  logic                        cmd_b_en;
  logic [2:0]                  cmd_a_op;
  logic [1:0]                  cmd_b_op;

  logic signed [IN_WIDTH-1:0]  A;
  logic signed [IN_WIDTH-1:0]  B;
  logic                        a_en;
  logic                        b_en;
  logic [2:0]                  a_op;
  logic [1:0]                  b_op;
  logic                        ALU_en;
  logic [OUT_WIDTH-1:0]        C;

  logic                        res_valid;
  logic                        res_ready;
  logic [OUT_WIDTH-1:0]        res_data;
  logic [7:0]                  issued_cnt;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_a_en, cmd_b_en, cmd_a_op, cmd_b_op,
    output C, res_ready,
    input  cmd_ready, A, B, a_en, b_en, a_op, b_op, ALU_en,
    input  res_valid, res_data, issued_cnt
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_a_en, cmd_b_en, cmd_a_op, cmd_b_op,
    input  C, res_ready,
    output cmd_ready, A, B, a_en, b_en, a_op, b_op, ALU_en,
    output res_valid, res_data, issued_cnt
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands in a small FIFO and issues them one at a time:
// strobe the ALU, capture its result a cycle later, hold it until accepted.
module alu_cmd_issuer #(
  parameter int IN_WIDTH  = 5,
  parameter int OUT_WIDTH = 6,
  parameter int DEPTH     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_cmd_issuer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic signed [IN_WIDTH-1:0] a;
    logic signed [IN_WIDTH-1:0] b;
    logic                       a_en;
    logic                       b_en;
    logic [2:0]                 a_op;
    logic [1:0]                 b_op;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  cmd_t                 mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  state_t               state_q;
  cmd_t                 cmd_q;
  logic                 alu_en_q;
  logic                 res_valid_q;
  logic [OUT_WIDTH-1:0] res_data_q;
  logic [7:0]           issued_cnt_q;

  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  cmd_t                 wr_entry;
  cmd_t                 head;

  assign fifo_empty    = (cnt_q == '0);
  assign bus.cmd_ready = (cnt_q != CNT_W'(DEPTH));
  assign head          = mem_q[rd_ptr_q];

  // A pop happens exactly when the FSM is about to enter ISSUE: from IDLE, or
  // straight out of HOLD on the result handshake.
  always_comb begin
    push = bus.cmd_valid && bus.cmd_ready;
    pop  = !fifo_empty &&
           ((state_q == IDLE) || ((state_q == HOLD) && bus.res_ready));

    wr_entry.a    = bus.cmd_a;
    wr_entry.b    = bus.cmd_b;
    wr_entry.a_en = bus.cmd_a_en;
    wr_entry.b_en = bus.cmd_b_en;
    wr_entry.a_op = bus.cmd_a_op;
    wr_entry.b_op = bus.cmd_b_op;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // The ALU operand/control registers only load on a pop, so they keep the
  // last issued command through WAIT, HOLD and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      alu_en_q     <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      issued_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            cmd_q    <= head;
            alu_en_q <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          alu_en_q <= 1'b0;
          state_q  <= WAIT;
        end
        WAIT: begin
          res_data_q  <= bus.C;
          res_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (bus.res_ready) begin
            issued_cnt_q <= issued_cnt_q + 8'd1;
            res_valid_q  <= 1'b0;
            if (pop) begin
              cmd_q    <= head;
              alu_en_q <= 1'b1;
              state_q  <= ISSUE;
            end else begin
              state_q  <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.A          = cmd_q.a;
  assign bus.B          = cmd_q.b;
  assign bus.a_en       = cmd_q.a_en;
  assign bus.b_en       = cmd_q.b_en;
  assign bus.a_op       = cmd_q.a_op;
  assign bus.b_op       = cmd_q.b_op;
  assign bus.ALU_en     = alu_en_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.issued_cnt = issued_cnt_q;

endmodule
